// File: rtl/pam4_pkg.sv
// pam4_pkg: constants and types shared by the PAM-4 receive path.
//   - slicer level indices and their Gray-decoded bit pairs
//   - PRBS31 polynomial taps (x^31 + x^28 + 1) and history length
//   - checker state encoding
//   - gray_decode(): level index -> 2-bit symbol, MSB is the earlier bit
package pam4_pkg;

    localparam logic [1:0] LEVEL_L0 = 2'd0;
    localparam logic [1:0] LEVEL_L1 = 2'd1;
    localparam logic [1:0] LEVEL_L2 = 2'd2;
    localparam logic [1:0] LEVEL_L3 = 2'd3;

    localparam logic [1:0] GRAY_L0 = 2'b00;
    localparam logic [1:0] GRAY_L1 = 2'b01;
    localparam logic [1:0] GRAY_L2 = 2'b11;
    localparam logic [1:0] GRAY_L3 = 2'b10;

    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;
    localparam int PRBS_LEN   = 31;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [1:0] gray_decode(input logic [1:0] level);
        logic [1:0] sym;
        case (level)
            LEVEL_L0: sym = GRAY_L0;
            LEVEL_L1: sym = GRAY_L1;
            LEVEL_L2: sym = GRAY_L2;
            default:  sym = GRAY_L3;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/pam4_slicer.sv
// pam4_slicer: registered PAM-4 decision slicer with Gray decode.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   signal_in         received voltage sample, signed
//   signal_in_valid   sample qualifier
//   symbol_out        decoded bit pair, [1] = earlier bit; holds while invalid
//   symbol_out_valid  signal_in_valid delayed by one cycle
module pam4_slicer
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    output logic        [1:0]                   symbol_out,
    output logic                                symbol_out_valid
);

    localparam logic signed [SIGNAL_RESOLUTION-1:0] POS_THRESH = SIGNAL_RESOLUTION'(SYMBOL_SEPERATION);
    localparam logic signed [SIGNAL_RESOLUTION-1:0] NEG_THRESH = -POS_THRESH;
    localparam logic signed [SIGNAL_RESOLUTION-1:0] ZERO       = '0;

    logic [1:0] level;

    // Three signed thresholds split the input range into the four levels;
    // a sample exactly on a threshold belongs to the level above it.
    always_comb begin
        level = LEVEL_L3;
        if (signal_in < NEG_THRESH) begin
            level = LEVEL_L0;
        end else if (signal_in < ZERO) begin
            level = LEVEL_L1;
        end else if (signal_in < POS_THRESH) begin
            level = LEVEL_L2;
        end
    end

    // The valid flag always follows the input; the symbol only updates on
    // valid samples so downstream logic sees a stable value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            symbol_out       <= 2'b00;
            symbol_out_valid <= 1'b0;
        end else begin
            symbol_out_valid <= signal_in_valid;
            if (signal_in_valid) begin
                symbol_out <= gray_decode(level);
            end
        end
    end

endmodule

// File: rtl/pam4_rx_checker.sv
// pam4_rx_checker: PAM-4 slicer followed by a self-synchronising PRBS31
// checker with lock detection and saturating bit/error counters.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   signal_in         received voltage sample, signed
//   signal_in_valid   sample qualifier
//   clear_counters    pulse that zeroes bit_count and err_count
//   symbol_out        Gray-decoded bit pair from the slicer
//   symbol_out_valid  qualifier for symbol_out
//   locked            checker is in the LOCKED state
//   bit_error         pulse when the current pair had a checked error
//   bit_count         bits checked while locked (saturating)
//   err_count         bit errors seen while locked (saturating)
module pam4_rx_checker
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int LOCK_COUNT        = 64,
    parameter int LOSS_WINDOW       = 256,
    parameter int LOSS_ERRORS       = 8,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic                                clear_counters,
    output logic        [1:0]                   symbol_out,
    output logic                                symbol_out_valid,
    output logic                                locked,
    output logic                                bit_error,
    output logic        [CNT_WIDTH-1:0]         bit_count,
    output logic        [CNT_WIDTH-1:0]         err_count
);

    localparam int TAP_HI = PRBS_TAP_A - 1;
    localparam int TAP_LO = PRBS_TAP_B - 1;

    localparam int FILL_W = $clog2(PRBS_LEN + 2) + 1;
    localparam int GOOD_W = $clog2(LOCK_COUNT + 2) + 1;
    localparam int WINB_W = $clog2(LOSS_WINDOW + 2) + 1;
    localparam int WINE_W = $clog2(LOSS_ERRORS + 2) + 1;

    localparam logic [FILL_W-1:0]  FILL_TARGET = FILL_W'(PRBS_LEN);
    localparam logic [FILL_W-1:0]  FILL_STEP   = FILL_W'(2);
    localparam logic [GOOD_W-1:0]  GOOD_TARGET = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0]  GOOD_STEP   = GOOD_W'(2);
    localparam logic [WINB_W-1:0]  WINB_TARGET = WINB_W'(LOSS_WINDOW);
    localparam logic [WINB_W-1:0]  WINB_STEP   = WINB_W'(2);
    localparam logic [WINE_W-1:0]  WINE_TARGET = WINE_W'(LOSS_ERRORS);
    localparam logic [CNT_WIDTH:0] CNT_STEP    = (CNT_WIDTH + 1)'(2);

    chk_state_t             state;
    logic [PRBS_LEN-1:0]    hist;
    logic [FILL_W-1:0]      fill_cnt;
    logic [GOOD_W-1:0]      good_cnt;
    logic [WINB_W-1:0]      win_bits;
    logic [WINE_W-1:0]      win_errs;

    logic                   err_hi;
    logic                   err_lo;
    logic [1:0]             pair_errs;
    logic [PRBS_LEN-1:0]    hist_next;
    logic [FILL_W-1:0]      fill_next;
    logic [GOOD_W-1:0]      good_next;
    logic [WINB_W-1:0]      win_bits_next;
    logic [WINE_W-1:0]      win_errs_next;
    logic [CNT_WIDTH:0]     bit_sum;
    logic [CNT_WIDTH:0]     err_sum;
    logic [CNT_WIDTH-1:0]   bit_count_inc;
    logic [CNT_WIDTH-1:0]   err_count_inc;

    pam4_slicer #(
        .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
        .SYMBOL_SEPERATION (SYMBOL_SEPERATION)
    ) u_slicer (
        .clk              (clk),
        .rst              (rst),
        .signal_in        (signal_in),
        .signal_in_valid  (signal_in_valid),
        .symbol_out       (symbol_out),
        .symbol_out_valid (symbol_out_valid)
    );

    // Both bits of the pair are checked in one cycle. The later bit's
    // prediction uses the history already shifted by the earlier bit, which
    // moves each tap down by one position. Received bits, never predicted
    // ones, enter the history so the checker resynchronises by itself.
    always_comb begin
        err_hi    = symbol_out[1] ^ (hist[TAP_HI] ^ hist[TAP_LO]);
        err_lo    = symbol_out[0] ^ (hist[TAP_HI-1] ^ hist[TAP_LO-1]);
        pair_errs = {1'b0, err_hi} + {1'b0, err_lo};
        hist_next = {hist[PRBS_LEN-3:0], symbol_out};

        fill_next     = fill_cnt + FILL_STEP;
        good_next     = (pair_errs != 2'd0) ? '0 : good_cnt + GOOD_STEP;
        win_bits_next = win_bits + WINB_STEP;
        win_errs_next = win_errs + {{(WINE_W-2){1'b0}}, pair_errs};

        // Counters add into one extra bit; a carry out means saturate.
        bit_sum       = {1'b0, bit_count} + CNT_STEP;
        err_sum       = {1'b0, err_count} + {{(CNT_WIDTH-1){1'b0}}, pair_errs};
        bit_count_inc = bit_sum[CNT_WIDTH] ? '1 : bit_sum[CNT_WIDTH-1:0];
        err_count_inc = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    end

    // Checker FSM and counters. Everything advances only on a valid pair,
    // except clear_counters which acts on any cycle and beats an increment.
    // Loss of lock is judged including the current pair's errors, and that
    // pair is still counted because it was checked while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            bit_error <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            bit_error <= 1'b0;
            if (symbol_out_valid) begin
                hist <= hist_next;
                case (state)
                    FILL: begin
                        fill_cnt <= fill_next;
                        if (fill_next >= FILL_TARGET) begin
                            state    <= SEARCH;
                            good_cnt <= '0;
                        end
                    end
                    SEARCH: begin
                        if (good_next >= GOOD_TARGET) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            good_cnt <= good_next;
                        end
                    end
                    LOCKED: begin
                        bit_count <= bit_count_inc;
                        err_count <= err_count_inc;
                        bit_error <= (pair_errs != 2'd0);
                        if (win_errs_next >= WINE_TARGET) begin
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            win_bits <= '0;
                            win_errs <= '0;
                        end else if (win_bits_next >= WINB_TARGET) begin
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            win_bits <= win_bits_next;
                            win_errs <= win_errs_next;
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear_counters) begin
                bit_count <= '0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pam4_rx_checker.sv
// tb_pam4_rx_checker: directed and randomized bench for pam4_rx_checker.
// A behavioural model (bit queue with index-based PRBS31 prediction) tracks
// the expected outputs every cycle; directed checks cover the key scenarios.
module tb_pam4_rx_checker;

    localparam int SR    = 8;
    localparam int SEP   = 56;
    localparam int LOCKN = 64;
    localparam int LWIN  = 256;
    localparam int LERR  = 8;
    localparam int CW    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [SR-1:0] signal_in;
    logic                 signal_in_valid;
    logic                 clear_counters;
    logic [1:0]           symbol_out;
    logic                 symbol_out_valid;
    logic                 locked;
    logic                 bit_error;
    logic [CW-1:0]        bit_count;
    logic [CW-1:0]        err_count;

    always #5 clk = ~clk;

    pam4_rx_checker #(
        .SIGNAL_RESOLUTION (SR),
        .SYMBOL_SEPERATION (SEP),
        .LOCK_COUNT        (LOCKN),
        .LOSS_WINDOW       (LWIN),
        .LOSS_ERRORS       (LERR),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .signal_in        (signal_in),
        .signal_in_valid  (signal_in_valid),
        .clear_counters   (clear_counters),
        .symbol_out       (symbol_out),
        .symbol_out_valid (symbol_out_valid),
        .locked           (locked),
        .bit_error        (bit_error),
        .bit_count        (bit_count),
        .err_count        (err_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] exp_sym;
    logic       exp_sym_valid;
    logic       exp_locked;
    logic       exp_bit_error;
    longint     exp_bit_count;
    longint     exp_err_count;
    int         phase;
    int         bits_seen;
    int         good_run;
    int         win_bits;
    int         win_errs;
    bit         rx_bits[$];
    bit         prbs_q[$];

    task automatic checkValue(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("symbol_out", CW'(symbol_out), CW'(exp_sym));
        checkValue("symbol_out_valid", CW'(symbol_out_valid), CW'(exp_sym_valid));
        checkValue("locked", CW'(locked), CW'(exp_locked));
        checkValue("bit_error", CW'(bit_error), CW'(exp_bit_error));
        checkValue("bit_count", bit_count, CW'(exp_bit_count));
        checkValue("err_count", err_count, CW'(exp_err_count));
    endtask

    function automatic logic [1:0] expSlice(input int v);
        if (v < -SEP)     return 2'b00;
        else if (v < 0)   return 2'b01;
        else if (v < SEP) return 2'b11;
        else              return 2'b10;
    endfunction

    function automatic int levelOf(input logic [1:0] p);
        case (p)
            2'b00:   return -84;
            2'b01:   return -28;
            2'b11:   return 28;
            default: return 84;
        endcase
    endfunction

    // PRBS31 transmitter: bit n = bit(n-31) xor bit(n-28), seed all ones.
    function automatic logic [1:0] nextPair();
        logic a;
        logic b;
        a = prbs_q[0] ^ prbs_q[3];
        prbs_q.push_back(a);
        void'(prbs_q.pop_front());
        b = prbs_q[0] ^ prbs_q[3];
        prbs_q.push_back(b);
        void'(prbs_q.pop_front());
        return {a, b};
    endfunction

    function automatic longint satAdd(input longint a, input longint b);
        longint s;
        s = a + b;
        if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
        return s;
    endfunction

    task automatic modelReset();
        exp_bit_count = 0;
        exp_err_count = 0;
        exp_locked    = 1'b0;
        exp_bit_error = 1'b0;
        phase         = 0;
        bits_seen     = 0;
        good_run      = 0;
        win_bits      = 0;
        win_errs      = 0;
        rx_bits.delete();
    endtask

    // Checker behaviour for one clock edge, given the symbol presented to it.
    task automatic modelStep(input logic [1:0] sym, input logic sv, input logic clr);
        int  errs;
        int  n;
        bit  b;
        errs = 0;
        exp_bit_error = 1'b0;
        if (sv) begin
            for (int k = 1; k >= 0; k--) begin
                b = sym[k];
                n = rx_bits.size();
                if (n >= 31 && (b != (rx_bits[n-31] ^ rx_bits[n-28]))) errs++;
                rx_bits.push_back(b);
            end
            if (phase == 0) begin
                bits_seen += 2;
                if (bits_seen >= 31) begin
                    phase    = 1;
                    good_run = 0;
                end
            end else if (phase == 1) begin
                good_run = (errs > 0) ? 0 : good_run + 2;
                if (good_run >= LOCKN) begin
                    phase    = 2;
                    win_bits = 0;
                    win_errs = 0;
                end
            end else begin
                exp_bit_count = satAdd(exp_bit_count, 2);
                exp_err_count = satAdd(exp_err_count, errs);
                exp_bit_error = (errs > 0);
                win_bits += 2;
                win_errs += errs;
                if (win_errs >= LERR) begin
                    phase    = 1;
                    good_run = 0;
                    win_bits = 0;
                    win_errs = 0;
                end else if (win_bits >= LWIN) begin
                    win_bits = 0;
                    win_errs = 0;
                end
            end
        end
        if (clr) begin
            exp_bit_count = 0;
            exp_err_count = 0;
        end
        exp_locked = (phase == 2);
    endtask

    // One cycle: check outputs at the falling edge, drive new inputs, then
    // advance the model to what the DUT will show at the next falling edge.
    task automatic applyStimulus(input int v, input logic vld, input logic clr, input logic r);
        logic [1:0] s1;
        logic       s1v;
        @(negedge clk);
        checkOutput();
        signal_in       = SR'(v);
        signal_in_valid = vld;
        clear_counters  = clr;
        rst             = r;
        s1  = exp_sym;
        s1v = exp_sym_valid;
        if (r) begin
            modelReset();
            exp_sym       = 2'b00;
            exp_sym_valid = 1'b0;
        end else begin
            modelStep(s1, s1v, clr);
            if (vld) exp_sym = expSlice(v);
            exp_sym_valid = vld;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(int'($urandom_range(0, 255)) - 128, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendPrbs(input int n, input logic toggle);
        for (int i = 0; i < n; i++) begin
            applyStimulus(levelOf(nextPair()), 1'b1, 1'b0, 1'b0);
            if (toggle) idle(1);
        end
    endtask

    int         pts[8];
    logic [1:0] pexp[8];
    logic [1:0] p;
    logic       found;
    logic       dropped;
    longint     drop_bits;
    logic       in_range;

    initial begin
        pts  = '{-84, -57, -56, -1, 0, 55, 56, 84};
        pexp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
        repeat (31) prbs_q.push_back(1'b1);

        rst             = 1'b1;
        signal_in       = '0;
        signal_in_valid = 1'b0;
        clear_counters  = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        exp_sym       = 2'b00;
        exp_sym_valid = 1'b0;

        $display("[TB] reset state");
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkValue("rst_locked", CW'(locked), 0);
        checkValue("rst_bit_count", bit_count, 0);
        checkValue("rst_symbol", CW'(symbol_out), 0);

        $display("[TB] slicer points");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pts[i], 1'b1, 1'b0, 1'b0);
            if (i > 0) checkValue("slice_point", CW'(symbol_out), CW'(pexp[i-1]));
        end
        idle(1);
        checkValue("slice_point", CW'(symbol_out), CW'(pexp[7]));
        idle(1);
        checkValue("slice_hold", CW'(symbol_out), CW'(pexp[7]));
        checkValue("slice_hold_valid", CW'(symbol_out_valid), 0);

        $display("[TB] clean PRBS31 lock");
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        sendPrbs(47, 1'b0);
        idle(2);
        checkValue("lock_not_yet", CW'(locked), 0);
        sendPrbs(1, 1'b0);
        idle(2);
        checkValue("lock_rise", CW'(locked), 1);
        checkValue("lock_bit_count", bit_count, 0);
        sendPrbs(20, 1'b0);
        idle(2);
        checkValue("clean_bit_count", bit_count, 40);
        checkValue("clean_err_count", err_count, 0);

        $display("[TB] single level error");
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            p = nextPair();
            if (p == 2'b10) begin
                applyStimulus(28, 1'b1, 1'b0, 1'b0);
                found = 1'b1;
            end else begin
                applyStimulus(levelOf(p), 1'b1, 1'b0, 1'b0);
            end
        end
        sendPrbs(20, 1'b0);
        idle(2);
        checkValue("flip_err_count", err_count, 3);
        checkValue("flip_locked", CW'(locked), 1);

        $display("[TB] toggled valid");
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        sendPrbs(68, 1'b1);
        idle(2);
        checkValue("toggle_locked", CW'(locked), 1);
        checkValue("toggle_bit_count", bit_count, 40);
        checkValue("toggle_err_count", err_count, 0);

        $display("[TB] clear with errored pair");
        p = nextPair();
        applyStimulus(levelOf(~p), 1'b1, 1'b0, 1'b0);
        applyStimulus(levelOf(nextPair()), 1'b1, 1'b1, 1'b0);
        idle(1);
        checkValue("clear_bit_count", bit_count, 0);
        checkValue("clear_err_count", err_count, 0);
        checkValue("clear_bit_error", CW'(bit_error), 1);

        $display("[TB] reset while locked");
        applyStimulus(levelOf(nextPair()), 1'b1, 1'b0, 1'b1);
        idle(1);
        checkValue("midrst_locked", CW'(locked), 0);
        checkValue("midrst_bit_count", bit_count, 0);
        checkValue("midrst_err_count", err_count, 0);
        checkValue("midrst_symbol", CW'(symbol_out), 0);
        checkValue("midrst_bit_error", CW'(bit_error), 0);
        sendPrbs(47, 1'b0);
        idle(2);
        checkValue("relock_not_yet", CW'(locked), 0);
        sendPrbs(1, 1'b0);
        idle(2);
        checkValue("relock", CW'(locked), 1);

        $display("[TB] random symbols while locked");
        dropped   = 1'b0;
        drop_bits = 0;
        for (int i = 0; i < 128; i++) begin
            applyStimulus(levelOf(2'($urandom_range(0, 3))), 1'b1, 1'b0, 1'b0);
            if (!exp_locked && !dropped) begin
                dropped   = 1'b1;
                drop_bits = exp_bit_count;
            end
        end
        idle(2);
        checkValue("rand_unlocked", CW'(locked), 0);
        checkValue("rand_freeze_bits", bit_count, CW'(drop_bits));
        in_range = (err_count >= 8) && (err_count <= 9);
        checkValue("rand_err_range", CW'(in_range), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
